// File: rtl/move_score_display.sv
// Move counter with a 4-digit multiplexed seven-segment display.
// Counts debounced fire presses in BCD, shows dashes on select errors and blinks once the game is won.
module move_score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic        error,
    input  logic        win,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] moves
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic          fire_q;
    logic          frozen_q,   frozen_d;
    logic [15:0]   moves_q,    moves_d;
    logic [RW-1:0] refresh_q,  refresh_d;
    logic [1:0]    idx_q,      idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [6:0]    seg_q,      seg_d;
    logic [3:0]    an_q,       an_d;
    logic          dp_q;

    logic          move_pulse;
    logic [15:0]   moves_inc;
    logic          carry;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    function automatic logic [6:0] hexToSeg(input logic [3:0] d);
        case (d)
            4'h0:    hexToSeg = 7'b1000000;
            4'h1:    hexToSeg = 7'b1111001;
            4'h2:    hexToSeg = 7'b0100100;
            4'h3:    hexToSeg = 7'b0110000;
            4'h4:    hexToSeg = 7'b0011001;
            4'h5:    hexToSeg = 7'b0010010;
            4'h6:    hexToSeg = 7'b0000010;
            4'h7:    hexToSeg = 7'b1111000;
            4'h8:    hexToSeg = 7'b0000000;
            4'h9:    hexToSeg = 7'b0010000;
            4'hA:    hexToSeg = 7'b0001000;
            4'hB:    hexToSeg = 7'b0000011;
            4'hC:    hexToSeg = 7'b1000110;
            4'hD:    hexToSeg = 7'b0100001;
            4'hE:    hexToSeg = 7'b0000110;
            default: hexToSeg = 7'b0001110;
        endcase
    endfunction

    assign move_pulse = fire & ~fire_q;

    // BCD increment with ripple carry; the count sticks at 9999.
    always_comb begin
        moves_inc = moves_q;
        carry     = (moves_q != 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (moves_q[4*i +: 4] == 4'd9) begin
                    moves_inc[4*i +: 4] = 4'd0;
                end else begin
                    moves_inc[4*i +: 4] = moves_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        frozen_d = frozen_q | win;
        moves_d  = moves_q;
        if (move_pulse && !error && !frozen_q) begin
            moves_d = moves_inc;
        end

        refresh_d = refresh_q + RW'(1);
        idx_d     = idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end

        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (frozen_q) begin
            blink_on_d = blink_on_q;
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_digit = moves_q[3:0];
        cur_blank = 1'b0;
        case (idx_q)
            2'd0: begin
                cur_digit = moves_q[3:0];
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = moves_q[7:4];
                cur_blank = (moves_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_digit = moves_q[11:8];
                cur_blank = (moves_q[15:8] == 8'h00);
            end
            default: begin
                cur_digit = moves_q[15:12];
                cur_blank = (moves_q[15:12] == 4'h0);
            end
        endcase

        seg_d = cur_blank ? SEG_BLANK : hexToSeg(cur_digit);
        if (error) begin
            seg_d = SEG_DASH;
        end
        an_d = blink_on_q ? ~(4'b0001 << idx_q) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q      <= 1'b1;
            frozen_q    <= 1'b0;
            moves_q     <= 16'h0000;
            refresh_q   <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
        end else begin
            fire_q      <= fire;
            frozen_q    <= frozen_d;
            moves_q     <= moves_d;
            refresh_q   <= refresh_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= 1'b1;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign moves = moves_q;

endmodule

// File: tb/tb_move_score_display.sv
// Directed bench for move_score_display with a small behavioural model feeding a moves scoreboard.
// Display scan, blanking, dashes and blink are checked against hand-derived patterns.
module tb_move_score_display;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fire = 1'b0;
    logic        error = 1'b0;
    logic        win = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] moves;

    int checks = 0;
    int errors = 0;

    int  modelCount  = 0;
    bit  modelFrozen = 1'b0;
    bit  modelFireQ  = 1'b1;
    logic [15:0] expQ[$];

    move_score_display #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fire (fire),
        .error(error),
        .win  (win),
        .seg  (seg),
        .an   (an),
        .dp   (dp),
        .moves(moves)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int n);
        toBcd = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] exp;
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkVal("moves scoreboard", moves, exp);
        end
    endtask

    // One clock step: check the previous step's result, then drive and model the new inputs.
    task automatic applyStimulus(input logic r, input logic f, input logic e, input logic w);
        @(negedge clk);
        checkOutput();
        reset = r;
        fire  = f;
        error = e;
        win   = w;
        if (r) begin
            modelCount  = 0;
            modelFrozen = 1'b0;
            modelFireQ  = 1'b1;
        end else begin
            if (f && !modelFireQ && !e && !modelFrozen) begin
                modelCount = (modelCount < 9999) ? modelCount + 1 : 9999;
            end
            if (w) begin
                modelFrozen = 1'b1;
            end
            modelFireQ = f;
        end
        expQ.push_back(toBcd(modelCount));
    endtask

    task automatic firePulse(input logic e);
        applyStimulus(1'b0, 1'b1, e, 1'b0);
        applyStimulus(1'b0, 1'b0, e, 1'b0);
    endtask

    task automatic firePulses(input int n);
        for (int i = 0; i < n; i++) begin
            firePulse(1'b0);
        end
    endtask

    task automatic scanDigits(input string tag, input logic e, input logic [6:0] exp3,
                              input logic [6:0] exp2, input logic [6:0] exp1, input logic [6:0] exp0);
        logic [6:0] got[4];
        bit         seen[4];
        logic [6:0] expd[4];
        expd[0] = exp0;
        expd[1] = exp1;
        expd[2] = exp2;
        expd[3] = exp3;
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0;
            got[d]  = 7'h00;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, e, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, e, 1'b0);
            for (int d = 0; d < 4; d++) begin
                if (an == ~(4'b0001 << d)) begin
                    seen[d] = 1'b1;
                    got[d]  = seg;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checkVal($sformatf("%s digit%0d seg", tag, d),
                     seen[d] ? {9'd0, got[d]} : 16'hxxxx, {9'd0, expd[d]});
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("reset seg", {9'd0, seg}, {9'd0, BLANK});
        checkVal("reset an", {12'd0, an}, 16'h000F);
        checkVal("reset dp", {15'd0, dp}, 16'h0001);
        checkVal("reset moves", moves, 16'h0000);

        // Anode scan order and wrap
        for (int m = 1; m <= 21; m++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (m >= 2) begin
                checkVal($sformatf("an scan step %0d", m), {12'd0, an},
                         {12'd0, ~(4'b0001 << (((m - 2) / 4) % 4))});
            end
        end

        // Three presses and leading-zero blanking
        firePulses(3);
        checkVal("three presses", moves, 16'h0003);
        scanDigits("count 3", 1'b0, BLANK, BLANK, BLANK, S3);
        checkVal("dp idle", {15'd0, dp}, 16'h0001);

        // Press during error is dropped; dashes everywhere; count comes back afterwards
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        firePulse(1'b1);
        scanDigits("error", 1'b1, DASH, DASH, DASH, DASH);
        checkVal("moves kept in error", moves, 16'h0003);
        scanDigits("after error", 1'b0, BLANK, BLANK, BLANK, S3);

        // Carry 0009 -> 0010, inner zero not blanked
        firePulses(6);
        checkVal("preload 9", moves, 16'h0009);
        firePulse(1'b0);
        checkVal("carry to 10", moves, 16'h0010);
        scanDigits("count 10", 1'b0, BLANK, BLANK, S1, S0);

        // Saturation at 9999
        firePulses(9989);
        checkVal("preload 9999", moves, 16'h9999);
        firePulse(1'b0);
        checkVal("saturate 9999", moves, 16'h9999);
        scanDigits("count 9999", 1'b0, S9, S9, S9, S9);

        // Fire held high across reset release
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkVal("fire held over reset", moves, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of counting and scanning
        firePulses(42);
        checkVal("count 42", moves, 16'h0042);
        scanDigits("count 42", 1'b0, BLANK, BLANK, S4, S2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("mid reset moves", moves, 16'h0000);
        checkVal("mid reset an", {12'd0, an}, 16'h000F);
        checkVal("mid reset seg", {9'd0, seg}, {9'd0, BLANK});

        // Win in the same cycle as a press, then frozen with blinking anodes
        firePulses(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 33; j++) begin
            applyStimulus(1'b0, 1'(j % 2), 1'b0, 1'b0);
            checkVal($sformatf("blink off at %0d", j), {15'd0, an == 4'b1111},
                     {15'd0, (j >= 2) && (((j - 2) / 8) % 2 == 1)});
        end
        checkVal("frozen count", moves, 16'h0003);

        // Error still shows dashes while frozen
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("frozen error dash", {9'd0, seg}, {9'd0, DASH});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Only reset leaves the frozen state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        firePulse(1'b0);
        checkVal("unfrozen by reset", moves, 16'h0001);

        @(negedge clk);
        checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_score_display.md
MOVE_SCORE_DISPLAY -- requirements
Module: move_score_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit scan slot (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period when frozen.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fire  input  1  debounced fire level from the fire-button debouncer.
REQ-006 SHALL have port error  input  1  row/column select error level.
REQ-007 SHALL have port win  input  1  win level from the win checker.
REQ-008 SHALL have port seg  output  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-009 SHALL have port an  output  4  active-low digit anodes; an[0] is the rightmost (ones) digit.
REQ-010 SHALL have port dp  output  1  active-low decimal point, held high (off).
REQ-011 SHALL have port moves  output  16  packed BCD move count, [3:0] = ones ... [15:12] = thousands.

Function
REQ-012 SHALL register fire into fire_q each cycle; move pulse = fire & ~fire_q.
REQ-013 SHALL increment moves by one BCD step on a move pulse only when error=0 and frozen=0; increment visible in moves the next cycle.
REQ-014 SHALL carry between BCD digits: any digit at 9 rolls to 0 with carry into the next digit.
REQ-015 SHALL saturate at 9999; a further valid pulse leaves moves at 16'h9999.
REQ-016 SHALL ignore a move pulse (no count, no deferred count) while error=1.
REQ-017 SHALL set frozen on the first cycle win=1 and clear it only on reset; a pulse in that same cycle still counts.
REQ-018 SHALL run a refresh counter 0..REFRESH_DIV-1; at terminal count, reset to 0 and advance the 2-bit digit index 0->1->2->3->0.
REQ-019 SHALL drive an as one-hot low at index (an[idx]=0, others 1) when displaying, registered one cycle after the index.
REQ-020 SHALL drive seg with the hex-to-7-segment pattern of the BCD digit at idx (0 = 7'b1000000, 1 = 7'b1111001, ..., 9 = 7'b0010000).
REQ-021 SHALL blank leading zeros: digits 3..1 with seg = 7'b1111111 if they and all higher digits are 0; digit 0 always shown.
REQ-022 SHALL, while error=1, show seg = 7'b0111111 (dash) on every digit, overriding count and blanking; the count is retained.
REQ-023 SHALL, while frozen=1, toggle a blink phase every BLINK_DIV cycles, starting "on"; in the "off" phase an = 4'b1111.
REQ-024 SHALL give error priority over blink: with error=1 and frozen=1, dashes shown and blink still gates an.
REQ-025 SHALL register all outputs (seg, an, dp, moves); no combinational path from input to output.

Reset
REQ-026 SHALL on reset=1 set moves=16'h0000, frozen=0, fire_q=1, refresh counter=0, idx=0, blink phase=on, seg=7'b1111111, an=4'b1111, dp=1.
REQ-027 SHALL set fire_q to 1 on reset so that fire held high across reset release produces no count.
REQ-028 SHALL have reset override every other input in the same cycle, including mid-scan, mid-blink and at saturation.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-029 SHALL cover: reset, then three separate 1->0 fire pulses with error=0 -> moves=16'h0003; scan shows "3" on an[0] and blank digits 1..3.
REQ-030 SHALL cover: preload to 0009 by pulses, one more pulse -> moves=16'h0010; preload to 9999 then pulse -> moves stays 16'h9999.
REQ-031 SHALL cover: error=1 during a fire pulse -> moves unchanged and seg=7'b0111111 on all four anodes; error drops -> prior count redisplayed.
REQ-032 SHALL cover: win and a fire pulse in the same cycle -> count +1, then frozen; later pulses -> no change; an = 4'b1111 for 8 cycles every 16.
REQ-033 SHALL cover: fire held high through reset release -> moves=16'h0000; reset mid-count at 0042 -> moves=0, an=4'b1111 next cycle.
REQ-034 SHALL cover: an steps 1110, 1101, 1011, 0111 every 4 cycles and wraps back to 1110.
